// File: rtl/pwm_capture_monitor.sv
// Multi-channel PWM capture: per-channel synchroniser, edge counting, period/high-time
// measurement and window checking with stuck-signal detection.
module pwm_capture_monitor #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EDGES       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [CHANNELS-1:0]       pwm_in,
  input  logic                      start,
  input  logic [CNT_W-1:0]          min_period,
  input  logic [CNT_W-1:0]          max_period,
  input  logic [CNT_W-1:0]          min_high,
  input  logic [CNT_W-1:0]          max_high,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       pass,
  output logic                      any_fail,
  output logic [CHANNELS*8-1:0]     edge_count,
  output logic [CHANNELS*CNT_W-1:0] last_period,
  output logic [CHANNELS*CNT_W-1:0] last_high
);

  localparam logic [CNT_W-1:0] PCNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       EDGES_B  = 8'(EDGES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_DONE
  } state_t;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   period_bad;
    logic                   high_bad;
    state_t                 state;
    logic [CNT_W-1:0]       pcnt;
    logic [CNT_W-1:0]       hcnt;
    logic                   fail_q;
    logic [7:0]             ecnt;
    logic [CNT_W-1:0]       lp;
    logic [CNT_W-1:0]       lh;
    logic                   done_q;
    logic                   pass_q;

    assign s          = sync_q[SYNC_STAGES-1];
    assign rise       = s & ~prev_q;
    assign fall       = ~s & prev_q;
    assign period_bad = (pcnt < min_period) || (pcnt > max_period);
    assign high_bad   = (hcnt < min_high) || (hcnt > max_high);

    // start takes priority over any edge in the same cycle, so that rise is dropped
    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        sync_q <= '0;
        prev_q <= 1'b0;
        state  <= ST_IDLE;
        pcnt   <= '0;
        hcnt   <= '0;
        fail_q <= 1'b0;
        ecnt   <= '0;
        lp     <= '0;
        lh     <= '0;
        done_q <= 1'b0;
        pass_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in[i]};
        prev_q <= s;
        if (start) begin
          state  <= ST_ARMED;
          pcnt   <= '0;
          hcnt   <= '0;
          fail_q <= 1'b0;
          ecnt   <= '0;
          lp     <= '0;
          lh     <= '0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end else begin
          case (state)
            ST_ARMED: begin
              if (rise) begin
                ecnt  <= 8'd1;
                pcnt  <= CNT_ONE;
                hcnt  <= CNT_ONE;
                state <= ST_MEASURE;
              end
            end
            ST_MEASURE: begin
              if (s) hcnt <= hcnt + CNT_ONE;
              if (fall) begin
                lh <= hcnt;
                if (high_bad) fail_q <= 1'b1;
              end
              if (rise) begin
                lp   <= pcnt;
                pcnt <= CNT_ONE;
                hcnt <= CNT_ONE;
                if (ecnt != 8'hFF) ecnt <= ecnt + 8'd1;
                if (period_bad) fail_q <= 1'b1;
                if (ecnt + 8'd1 == EDGES_B) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                  pass_q <= ~(fail_q | period_bad);
                end
              end else if (pcnt == PCNT_MAX) begin
                // no rise for a full counter span: signal stuck or absent
                state  <= ST_DONE;
                done_q <= 1'b1;
                pass_q <= 1'b0;
              end else begin
                pcnt <= pcnt + CNT_ONE;
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign done[i]                    = done_q;
    assign pass[i]                    = pass_q;
    assign edge_count[i*8 +: 8]       = ecnt;
    assign last_period[i*CNT_W +: CNT_W] = lp;
    assign last_high[i*CNT_W +: CNT_W]   = lh;
  end

  // One cycle behind done/pass by construction
  always_ff @(posedge HCLK) begin
    if (HRESET) any_fail <= 1'b0;
    else        any_fail <= |(done & ~pass);
  end

endmodule

// File: tb/tb_pwm_capture_monitor.sv
// Directed bench for pwm_capture_monitor: table of waveform/window scenarios plus
// hand-written sequences for stuck input, mid-run reset and start/rise collision.
module tb_pwm_capture_monitor;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned CNT_W    = 8;

  logic                      HCLK = 1'b0;
  logic                      HRESET;
  logic [CHANNELS-1:0]       pwm_in;
  logic                      start;
  logic [CNT_W-1:0]          min_period, max_period, min_high, max_high;
  logic [CHANNELS-1:0]       done, pass;
  logic                      any_fail;
  logic [CHANNELS*8-1:0]     edge_count;
  logic [CHANNELS*CNT_W-1:0] last_period, last_high;

  always #5 HCLK = ~HCLK;

  pwm_capture_monitor #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .EDGES(5), .SYNC_STAGES(2)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .pwm_in(pwm_in), .start(start),
    .min_period(min_period), .max_period(max_period),
    .min_high(min_high), .max_high(max_high),
    .done(done), .pass(pass), .any_fail(any_fail), .edge_count(edge_count),
    .last_period(last_period), .last_high(last_high)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int per[2];
  int hi[2];
  int ph[2];
  bit run[2];
  int q0[$];

  typedef struct {
    string      name;
    int         p0, h0, p1, h1;
    bit         jit;
    logic [1:0] pass;
    int         lp0, lh0, lp1, lh1;
    bit         af;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one clock; waveform generators update just after the edge
  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (run[i]) begin
        pwm_in[i] = (ph[i] < hi[i]);
        ph[i]++;
        if (ph[i] >= per[i]) begin
          ph[i] = 0;
          if (i == 0 && q0.size() > 0) per[0] = q0.pop_front();
        end
      end
    end
  endtask

  task automatic quiet(input int n);
    run[0] = 1'b0;
    run[1] = 1'b0;
    pwm_in = '0;
    repeat (n) tick();
  endtask

  task automatic launch(input int p0, input int h0, input int p1, input int h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    per[0] = p0; hi[0] = h0; ph[0] = p0 - 5;
    per[1] = p1; hi[1] = h1; ph[1] = p1 - 5;
    run[0] = 1'b1;
    run[1] = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    quiet(5);
    q0.delete();
    if (v.jit) q0 = {100, 100, 120, 100};
    launch(v.p0, v.h0, v.p1, v.h1);
    seen = 1'b0;
    for (int k = 0; k < 1500 && done != 2'b11; k++) begin
      tick();
      if (!seen && (done & ~pass) != 2'b00) begin
        seen = 1'b1;
        chk({v.name, " any_fail_before_lag"}, int'(any_fail), 0);
        tick();
        chk({v.name, " any_fail_after_lag"}, int'(any_fail), 1);
      end
    end
    chk({v.name, " done"}, int'(done), 3);
    tick();
    chk({v.name, " any_fail"}, int'(any_fail), int'(v.af));
    chk({v.name, " pass"}, int'(pass), int'(v.pass));
    chk({v.name, " edges0"}, int'(edge_count[7:0]), 5);
    chk({v.name, " edges1"}, int'(edge_count[15:8]), 5);
    chk({v.name, " period0"}, int'(last_period[7:0]), v.lp0);
    chk({v.name, " high0"}, int'(last_high[7:0]), v.lh0);
    chk({v.name, " period1"}, int'(last_period[15:8]), v.lp1);
    chk({v.name, " high1"}, int'(last_high[15:8]), v.lh1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " pass"}, int'(pass), 0);
    chk({nm, " any_fail"}, int'(any_fail), 0);
    chk({nm, " edge_count"}, int'(edge_count), 0);
    chk({nm, " last_period"}, int'(last_period), 0);
    chk({nm, " last_high"}, int'(last_high), 0);
  endtask

  vec_t vecs[5];

  initial begin
    int t0;
    int t1;
    int k;

    // window: period [90,110], high [40,60]
    vecs[0] = '{"p100h50_p100h80", 100, 50, 100, 80, 1'b0, 2'b01, 100, 50, 100, 80, 1'b1};
    vecs[1] = '{"lower_upper_edges", 90, 40, 110, 60, 1'b0, 2'b11, 90, 40, 110, 60, 1'b0};
    vecs[2] = '{"period_outside", 89, 40, 111, 60, 1'b0, 2'b00, 89, 40, 111, 60, 1'b1};
    vecs[3] = '{"high_outside", 100, 39, 100, 61, 1'b0, 2'b00, 100, 39, 100, 61, 1'b1};
    vecs[4] = '{"jitter", 100, 50, 95, 45, 1'b1, 2'b10, 100, 50, 95, 45, 1'b1};

    HRESET = 1'b1;
    start  = 1'b0;
    pwm_in = '0;
    run[0] = 1'b0;
    run[1] = 1'b0;
    min_period = 8'd90;  max_period = 8'd110;
    min_high   = 8'd40;  max_high   = 8'd60;
    repeat (3) tick();
    chk_all_zero("reset");
    HRESET = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Input held low after start: channel stays armed, never completes
    quiet(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    chk("stuck_low done", int'(done), 0);
    chk("stuck_low edges", int'(edge_count), 0);

    // Single rise then constant high: completes with fail 255 cycles after the rise
    pwm_in[0] = 1'b1;
    k = 0;
    while (edge_count[7:0] != 8'd1 && k < 10) begin tick(); k++; end
    chk("stuck_high first_rise", int'(edge_count[7:0]), 1);
    t1 = cyc;
    k = 0;
    while (!done[0] && k < 300) begin tick(); k++; end
    chk("stuck_high latency", cyc - t1, 255);
    chk("stuck_high done", int'(done), 1);
    chk("stuck_high pass", int'(pass), 0);
    chk("stuck_high edges", int'(edge_count[7:0]), 1);
    chk("stuck_high period", int'(last_period[7:0]), 0);
    chk("stuck_high high", int'(last_high[7:0]), 0);

    // Reset in the middle of a measurement, with a simultaneous start
    quiet(5);
    q0.delete();
    launch(100, 50, 100, 50);
    k = 0;
    while (edge_count[7:0] != 8'd3 && k < 600) begin tick(); k++; end
    chk("midreset reached3", int'(edge_count[7:0]), 3);
    HRESET = 1'b1;
    start  = 1'b1;
    tick();
    HRESET = 1'b0;
    start  = 1'b0;
    chk_all_zero("midreset");
    repeat (300) tick();
    chk("midreset idle edges", int'(edge_count), 0);
    chk("midreset idle done", int'(done), 0);
    run_vec('{"after_reset", 100, 50, 100, 50, 1'b0, 2'b11, 100, 50, 100, 50, 1'b0});

    // start in the same cycle the rise is detected: that rise is dropped
    quiet(5);
    q0.delete();
    per[0] = 100; hi[0] = 50; ph[0] = 0;
    run[0] = 1'b1;
    tick();
    t0 = cyc;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("collide edges_after_start", int'(edge_count[7:0]), 0);
    k = 0;
    while (!done[0] && k < 700) begin
      if (cyc == t0 + 403) chk("collide not_done_early", int'(done[0]), 0);
      tick();
      k++;
    end
    chk("collide done_time", cyc - t0, 503);
    chk("collide pass", int'(pass[0]), 1);
    chk("collide edges", int'(edge_count[7:0]), 5);
    chk("collide period", int'(last_period[7:0]), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
